pwm_multi_chan: RTL and testbench

//  Parametrised multi-channel PWM generator for the motor H-bridges; successor to the single 11-bit PWM.
//  One shared free-running period counter and CH independent duty channels.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_deadtime.sv | 109 ++++++++++
 rtl/pwm_multi_chan.sv | 76 +++++++
 tb/tb_pwm_multi_chan.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and constants for the multi-channel PWM generator.
// Default duty width is 11 bits; the top recomputes its own width-dependent constants.
package pwm_pkg;

    localparam int PWM_WIDTH = 11;

    typedef logic [PWM_WIDTH-1:0] duty_t;

    localparam duty_t CNT_MAX = '1;

    typedef enum logic [2:0] {
        DT_OFF     = 3'd0,
        DT_WAIT_HI = 3'd1,
        DT_HI      = 3'd2,
        DT_WAIT_LO = 3'd3,
        DT_LO      = 3'd4
    } dt_state_t;

    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Per-channel output stage. With PWM_DEADTIME_EN defined it inserts DEADTIME idle
// cycles after every raw edge; otherwise it is a registered complementary pair.
module pwm_deadtime #(
    parameter int WIDTH    = 11,
    parameter int DEADTIME = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic raw,
    output logic hi,
    output logic lo
);

    if (DEADTIME < 0 || DEADTIME >= (2 ** WIDTH) / 2) begin : g_bad_deadtime
        $error("pwm_deadtime: DEADTIME must be below half the PWM period");
    end

`ifdef PWM_DEADTIME_EN
    import pwm_pkg::*;

    localparam int             DTW      = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
    localparam logic [DTW-1:0] DT_LAST  = DTW'((DEADTIME > 0) ? DEADTIME - 1 : 0);
    localparam dt_state_t      ENTER_HI = (DEADTIME > 0) ? DT_WAIT_HI : DT_HI;
    localparam dt_state_t      ENTER_LO = (DEADTIME > 0) ? DT_WAIT_LO : DT_LO;

    // The state register itself is the registered raw level, so no separate raw flop.
    dt_state_t      state, state_nxt;
    logic [DTW-1:0] dt_cnt, dt_cnt_nxt;

    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise missed branches infer latches.
        state_nxt  = state;
        dt_cnt_nxt = dt_cnt;
        if (!en) begin
            state_nxt  = DT_OFF;
            dt_cnt_nxt = '0;
        end else begin
            case (state)
                DT_OFF: begin
                    state_nxt  = raw ? ENTER_HI : ENTER_LO;
                    dt_cnt_nxt = '0;
                end
                DT_WAIT_HI: begin
                    if (!raw) begin
                        state_nxt  = ENTER_LO;
                        dt_cnt_nxt = '0;
                    end else if (dt_cnt == DT_LAST) begin
                        state_nxt = DT_HI;
                    end else begin
                        dt_cnt_nxt = dt_cnt + 1'b1;
                    end
                end
                DT_HI: begin
                    if (!raw) begin
                        state_nxt  = ENTER_LO;
                        dt_cnt_nxt = '0;
                    end
                end
                DT_WAIT_LO: begin
                    if (raw) begin
                        state_nxt  = ENTER_HI;
                        dt_cnt_nxt = '0;
                    end else if (dt_cnt == DT_LAST) begin
                        state_nxt = DT_LO;
                    end else begin
                        dt_cnt_nxt = dt_cnt + 1'b1;
                    end
                end
                DT_LO: begin
                    if (raw) begin
                        state_nxt  = ENTER_HI;
                        dt_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt  = DT_OFF;
                    dt_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= DT_OFF;
            dt_cnt <= '0;
        end else begin
            state  <= state_nxt;
            dt_cnt <= dt_cnt_nxt;
        end
    end

    // Decoded from a single state register, so hi and lo can never overlap.
    assign hi = (state == DT_HI);
    assign lo = (state == DT_LO);
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi <= 1'b0;
            lo <= 1'b0;
        end else begin
            hi <= raw;
            lo <= en & ~raw;
        end
    end
`endif

endmodule

// File: rtl/pwm_multi_chan.sv
// Multi-channel PWM: shared free-running counter, double-buffered duty applied at wrap.
// Define PWM_DEADTIME_EN to insert DEADTIME dead-band cycles on every output edge.
module pwm_multi_chan
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 11,
    parameter int CH       = 2,
    parameter int DEADTIME = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [CH*WIDTH-1:0] duty,
    input  logic                duty_vld,
    output logic                upd_pend,
    output logic                period_done,
    output logic [CH-1:0]       pwm_hi,
    output logic [CH-1:0]       pwm_lo
);

    localparam logic [WIDTH-1:0] CNT_TOP = WIDTH'(cnt_max(WIDTH));

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] pending [CH];
    logic [WIDTH-1:0] active  [CH];
    logic             wrap;
    logic             apply;

    assign wrap  = en && (cnt == CNT_TOP);
    assign apply = wrap || !en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            upd_pend    <= 1'b0;
            period_done <= 1'b0;
            // NOTE: these duty arrays are small flop banks, not RAM, so they take the async reset
            // like any other state; a RAM-mapped array would be left unreset.
            for (int i = 0; i < CH; i++) begin
                pending[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every register reading the pre-edge values.
            cnt         <= en ? cnt + 1'b1 : '0;
            period_done <= wrap;
            // A capture on the apply cycle keeps the flag set: the new value waits for the next wrap.
            upd_pend    <= duty_vld | (upd_pend & ~apply);
            for (int i = 0; i < CH; i++) begin
                if (duty_vld)
                    pending[i] <= duty[i*WIDTH +: WIDTH];
                if (apply && upd_pend)
                    active[i] <= pending[i];
            end
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_chan
        logic raw;

        assign raw = en & (cnt < active[i]);

        pwm_deadtime #(
            .WIDTH    (WIDTH),
            .DEADTIME (DEADTIME)
        ) u_deadtime (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .raw   (raw),
            .hi    (pwm_hi[i]),
            .lo    (pwm_lo[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi_chan.sv
// Self-checking bench for pwm_multi_chan; per-period high/low counts checked against
// a duty-level reference model (also valid with PWM_DEADTIME_EN defined).
module tb_pwm_multi_chan;

    localparam int WIDTH    = 11;
    localparam int CH       = 2;
    localparam int DEADTIME = 8;
    localparam int PERIOD   = 1 << WIDTH;

    typedef logic [CH*WIDTH-1:0] dvec_t;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          en       = 1'b0;
    logic          duty_vld = 1'b0;
    dvec_t         duty     = '0;
    logic          upd_pend;
    logic          period_done;
    logic [CH-1:0] pwm_hi;
    logic [CH-1:0] pwm_lo;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: duty in force this period, and the buffered request.
    int exp_active   [CH];
    int exp_pend_val [CH];
    bit exp_pend;

    always #10 clk = ~clk;

    pwm_multi_chan #(
        .WIDTH    (WIDTH),
        .CH       (CH),
        .DEADTIME (DEADTIME)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .duty        (duty),
        .duty_vld    (duty_vld),
        .upd_pend    (upd_pend),
        .period_done (period_done),
        .pwm_hi      (pwm_hi),
        .pwm_lo      (pwm_lo)
    );

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic dvec_t mk(input int c0, input int c1);
        dvec_t v;
        v[0 +: WIDTH]     = c0[WIDTH-1:0];
        v[WIDTH +: WIDTH] = c1[WIDTH-1:0];
        return v;
    endfunction

    // Clocks per period that the high side is on for duty d.
    function automatic int exp_hi(input int d);
`ifdef PWM_DEADTIME_EN
        return (d > DEADTIME) ? d - DEADTIME : 0;
`else
        return d;
`endif
    endfunction

    // Clocks per period the low side is on; -1 where it depends on earlier periods.
    function automatic int exp_lo(input int d);
`ifdef PWM_DEADTIME_EN
        if (d == 0)
            return -1;
        return (PERIOD - d > DEADTIME) ? PERIOD - d - DEADTIME : 0;
`else
        return PERIOD - d;
`endif
    endfunction

    task automatic wait_pd(input string tag);
        int k = 0;
        while (period_done !== 1'b1 && k < 3 * PERIOD) begin
            step();
            k++;
        end
        n_checks++;
        if (period_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s period_done timeout: got %b expected 1", tag, period_done);
        end
    endtask

    // Called on a period_done sample; measures one full period, optionally writing duty
    // after sample wr1_at / wr2_at (index PERIOD-1 is the wrap cycle). Ends on the next period_done.
    task automatic run_period(input string tag, input int wr1_at, input dvec_t v1,
                              input int wr2_at, input dvec_t v2);
        int    hi_cnt [CH];
        int    lo_cnt [CH];
        int    cur    [CH];
        int    overlap  = 0;
        int    pd_cnt   = 0;
        int    pend_err = 0;
        bit    pend_now = exp_pend;
        bit    wrap_wr  = 0;
        dvec_t wrap_v   = '0;
        dvec_t wv;
        for (int i = 0; i < CH; i++) begin
            hi_cnt[i] = 0;
            lo_cnt[i] = 0;
            cur[i]    = exp_active[i];
        end
        for (int j = 0; j <= PERIOD; j++) begin
            if (j > 0) begin
                step();
                for (int i = 0; i < CH; i++) begin
                    hi_cnt[i] += (pwm_hi[i] === 1'b1) ? 1 : 0;
                    lo_cnt[i] += (pwm_lo[i] === 1'b1) ? 1 : 0;
                end
                overlap += $countones(pwm_hi & pwm_lo);
                if (period_done === 1'b1)
                    pd_cnt++;
                if (j < PERIOD && upd_pend !== pend_now)
                    pend_err++;
            end
            duty_vld = 1'b0;
            if (j < PERIOD && (j == wr1_at || j == wr2_at)) begin
                wv       = (j == wr2_at) ? v2 : v1;
                duty     = wv;
                duty_vld = 1'b1;
                pend_now = 1'b1;
                if (j == PERIOD - 1) begin
                    wrap_wr = 1'b1;
                    wrap_v  = wv;
                end else begin
                    for (int i = 0; i < CH; i++)
                        exp_pend_val[i] = int'(wv[i*WIDTH +: WIDTH]);
                    exp_pend = 1'b1;
                end
            end
        end
        duty_vld = 1'b0;
        // Wrap: whatever was pending before the wrap cycle takes effect now.
        if (exp_pend)
            for (int i = 0; i < CH; i++)
                exp_active[i] = exp_pend_val[i];
        exp_pend = wrap_wr;
        if (wrap_wr)
            for (int i = 0; i < CH; i++)
                exp_pend_val[i] = int'(wrap_v[i*WIDTH +: WIDTH]);

        for (int i = 0; i < CH; i++) begin
            n_checks++;
            if (hi_cnt[i] !== exp_hi(cur[i])) begin
                n_fail++;
                $display("FAIL %s ch%0d hi_count: got %0d expected %0d (duty 0x%0h)",
                         tag, i, hi_cnt[i], exp_hi(cur[i]), cur[i]);
            end
            if (exp_lo(cur[i]) >= 0) begin
                n_checks++;
                if (lo_cnt[i] !== exp_lo(cur[i])) begin
                    n_fail++;
                    $display("FAIL %s ch%0d lo_count: got %0d expected %0d (duty 0x%0h)",
                             tag, i, lo_cnt[i], exp_lo(cur[i]), cur[i]);
                end
            end
        end
        n_checks++;
        if (overlap !== 0) begin
            n_fail++;
            $display("FAIL %s hi_lo_overlap: got %0d cycles expected 0", tag, overlap);
        end
        n_checks++;
        if (pd_cnt !== 1 || period_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s period_done_spacing: got %0d pulses (last %b) expected 1 at end",
                     tag, pd_cnt, period_done);
        end
        n_checks++;
        if (pend_err !== 0) begin
            n_fail++;
            $display("FAIL %s upd_pend_in_period: got %0d wrong cycles expected 0", tag, pend_err);
        end
        n_checks++;
        if (upd_pend !== exp_pend) begin
            n_fail++;
            $display("FAIL %s upd_pend_after_wrap: got %b expected %b", tag, upd_pend, exp_pend);
        end
    endtask

    task automatic count_to_first_pd(input string tag);
        int k = 0;
        do begin
            step();
            k++;
        end while (period_done !== 1'b1 && k < 3 * PERIOD);
        n_checks++;
        if (k !== PERIOD) begin
            n_fail++;
            $display("FAIL %s first_period_done: got %0d clks expected %0d", tag, k, PERIOD);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) step();
        n_checks += 4;
        if (pwm_hi !== '0) begin
            n_fail++;
            $display("FAIL reset pwm_hi: got %b expected 00", pwm_hi);
        end
        if (pwm_lo !== '0) begin
            n_fail++;
            $display("FAIL reset pwm_lo: got %b expected 00", pwm_lo);
        end
        if (upd_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL reset upd_pend: got %b expected 0", upd_pend);
        end
        if (period_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset period_done: got %b expected 0", period_done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < CH; i++) begin
            exp_active[i]   = 0;
            exp_pend_val[i] = 0;
        end
        exp_pend = 1'b0;
        step();
    endtask

    task automatic test_basic();
        duty     = mk(12'h400, 12'h000);
        duty_vld = 1'b1;
        step();
        duty_vld = 1'b0;
        n_checks++;
        if (upd_pend !== 1'b1) begin
            n_fail++;
            $display("FAIL basic upd_pend_capture: got %b expected 1", upd_pend);
        end
        step();
        exp_active[0] = 12'h400;
        exp_active[1] = 0;
        n_checks++;
        if (upd_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL basic upd_pend_idle_apply: got %b expected 0", upd_pend);
        end
        n_checks++;
        if (pwm_hi !== '0 || pwm_lo !== '0) begin
            n_fail++;
            $display("FAIL basic outputs_while_disabled: got hi=%b lo=%b expected 00/00", pwm_hi, pwm_lo);
        end
        en = 1'b1;
        count_to_first_pd("basic");
        run_period("basic", -1, '0, -1, '0);
        run_period("basic_repeat", -1, '0, -1, '0);
    endtask

    task automatic test_mid_period_update();
        run_period("mid_write", 12'h100, mk(12'h7FF, 0), -1, '0);
        run_period("mid_applied", -1, '0, -1, '0);
    endtask

    task automatic test_last_write_wins();
        run_period("two_writes", 12'h200, mk(12'h200, 12'h123), 12'h500, mk(12'h300, 12'h0AB));
        run_period("wrap_write", PERIOD - 1, mk(12'h005, 12'h600), -1, '0);
        run_period("wrap_pending", -1, '0, -1, '0);
        run_period("short_pulse", 12'h400, mk(12'h1F0, 12'h7FF), PERIOD - 1, mk(12'h004, 12'h000));
        run_period("old_pend_applied", -1, '0, -1, '0);
    endtask

    task automatic test_random();
        dvec_t v1;
        dvec_t v2;
        int    a1;
        int    a2;
        for (int n = 0; n < 5; n++) begin
            v1 = mk(int'($urandom_range(0, PERIOD - 1)), int'($urandom_range(0, PERIOD - 1)));
            v2 = mk(int'($urandom_range(0, PERIOD - 1)), int'($urandom_range(0, PERIOD - 1)));
            a1 = int'($urandom_range(0, PERIOD / 2));
            case ($urandom_range(0, 2))
                0:       a2 = -1;
                1:       a2 = PERIOD - 1;
                default: a2 = int'($urandom_range(PERIOD / 2 + 1, PERIOD - 2));
            endcase
            run_period("random", a1, v1, a2, v2);
        end
        run_period("random_settle", -1, '0, -1, '0);
    endtask

    task automatic test_en_drop();
        run_period("en_setup", 0, mk(12'h400, 12'h7FF), -1, '0);
        for (int j = 1; j <= 12'h300; j++)
            step();
        n_checks++;
        if (pwm_hi !== 2'b11) begin
            n_fail++;
            $display("FAIL en_drop hi_before_drop: got %b expected 11", pwm_hi);
        end
        en = 1'b0;
        step();
        n_checks++;
        if (pwm_hi !== '0 || pwm_lo !== '0) begin
            n_fail++;
            $display("FAIL en_drop outputs_next_clk: got hi=%b lo=%b expected 00/00", pwm_hi, pwm_lo);
        end
        duty     = mk(12'h080, 12'h000);
        duty_vld = 1'b1;
        step();
        duty_vld = 1'b0;
        step();
        exp_active[0] = 12'h080;
        exp_active[1] = 0;
        exp_pend      = 1'b0;
        n_checks++;
        if (upd_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop upd_pend_idle_apply: got %b expected 0", upd_pend);
        end
        en = 1'b1;
        count_to_first_pd("en_restart");
        run_period("en_restart", -1, '0, -1, '0);
    endtask

    task automatic test_reset_mid();
        for (int j = 1; j <= 10; j++)
            step();
        duty     = mk(12'h111, 12'h222);
        duty_vld = 1'b1;
        step();
        duty_vld = 1'b0;
        n_checks++;
        if (pwm_hi[0] !== 1'b1 || upd_pend !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid precondition: got hi0=%b upd_pend=%b expected 1/1", pwm_hi[0], upd_pend);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (pwm_hi !== '0 || pwm_lo !== '0 || upd_pend !== 1'b0 || period_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid async_clear: got hi=%b lo=%b upd_pend=%b pd=%b expected all 0",
                     pwm_hi, pwm_lo, upd_pend, period_done);
        end
        repeat (3) step();
        rst_n = 1'b1;
        for (int i = 0; i < CH; i++)
            exp_active[i] = 0;
        exp_pend = 1'b0;
        wait_pd("reset_mid");
        run_period("after_reset", -1, '0, -1, '0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mid_period_update();
        test_last_write_wins();
        test_random();
        test_en_drop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
